commit_trace_packer: RTL and testbench

- Synthesizable commit-trace producer attached to the processor's writeback/memory commit signals.
- Every cycle it samples the per-cycle commit event: register write, load, store and halt.
- It buffers events in a small queue and serializes each one into a packed stream of 16-bit words over a valid/ready interface.
- An off-chip or bench-side consumer can rebuild the REG/LOAD/STORE/HALT trace from that stream.

---
 rtl/commit_trace_packer.sv | 225 ++++++++++++++++++++++
 tb/tb_commit_trace_packer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_packer.sv
// commit_trace_packer: samples per-cycle commit events (register write, load,
// store, halt), buffers them in a small queue and serializes each entry as a
// sequence of 16-bit trace words over a valid/ready interface.
module commit_trace_packer #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [2:0]        WriteRegister,
    input  logic [15:0]       WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [15:0]       MemAddress,
    input  logic [15:0]       MemDataIn,
    input  logic [15:0]       MemDataOut,
    input  logic              Halt,
    output logic              tr_valid,
    output logic [15:0]       tr_data,
    input  logic              tr_ready,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic [15:0]       inst_count,
    output logic              done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_DEPTH    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] C_DEPTH_M1 = (PTR_W + 1)'(DEPTH - 1);

    // One queue entry holds everything a single commit cycle can report.
    typedef struct packed {
        logic        is_reg;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        logic        is_mem;
        logic        is_store;
        logic [15:0] addr;
        logic [15:0] mdata;
        logic        is_halt;
    } entry_t;

    typedef enum logic [3:0] {
        S_IDLE, S_MHDR, S_MADDR, S_MDATA, S_RHDR, S_RDATA, S_HHDR, S_HCNT, S_DONE
    } state_t;

    entry_t              r_queue [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic                r_halted;
    logic                r_overflow;
    logic [DROP_W-1:0]   r_drop_count;
    logic [15:0]         r_inst_count;
    state_t              r_state;
    logic                r_tr_valid;
    logic                r_done;

    logic                w_event;
    logic                w_room;
    logic                w_push;
    logic                w_drop;
    logic                w_commit;
    logic                w_pop;
    logic                w_accept;
    state_t              w_next_state;
    entry_t              w_new;
    entry_t              w_head;
    logic [7:0]          w_drop8;
    logic [15:0]         w_tr_data;

    // First word state for an entry: memory record, then REG, then HALT.
    function automatic state_t f_first(input entry_t e);
        if (e.is_mem)      return S_MHDR;
        else if (e.is_reg) return S_RHDR;
        else               return S_HHDR;
    endfunction

    // The halt header carries the low byte of the drop counter.
    if (DROP_W >= 8) begin : g_drop_wide
        assign w_drop8 = r_drop_count[7:0];
    end else begin : g_drop_narrow
        assign w_drop8 = {{(8 - DROP_W){1'b0}}, r_drop_count};
    end

    // Event detection and admission; one slot is held back for the halt entry.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_event  = RegWrite | MemRead | MemWrite | Halt;
        w_commit = !r_halted && (Halt | RegWrite | MemWrite);
        w_room   = Halt ? (r_count < C_DEPTH) : (r_count < C_DEPTH_M1);
        w_push   = !r_halted && w_event && w_room;
        w_drop   = !r_halted && w_event && !w_room;

        w_new          = '0;
        w_new.is_reg   = RegWrite;
        w_new.wreg     = WriteRegister;
        w_new.wdata    = WriteData;
        w_new.is_mem   = MemRead | MemWrite;
        w_new.is_store = MemWrite;
        w_new.addr     = MemAddress;
        w_new.mdata    = MemWrite ? MemDataIn : MemDataOut;
        w_new.is_halt  = Halt;
    end

    // Queue storage: written on push, addressed by the write pointer.
    // NOTE: the storage array has no reset; only pointers and count define
    // validity, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) r_queue[r_wr_ptr] <= w_new;
    end

    assign w_head = r_queue[r_rd_ptr];

    // Queue pointers and occupancy; push and pop on the same edge cancel out.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Commit counter, drop counter, overflow flag and halted latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst_count <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            if (w_commit && r_inst_count != 16'hFFFF)
                r_inst_count <= r_inst_count + 16'd1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != {DROP_W{1'b1}})
                    r_drop_count <= r_drop_count + 1'b1;
            end
            if (w_push && Halt) r_halted <= 1'b1;
        end
    end

    assign w_accept = r_tr_valid && tr_ready;

    // Next-state walk through the head entry's records; pop after its last word.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_next_state = f_first(w_head);
            S_MHDR:  if (w_accept) w_next_state = S_MADDR;
            S_MADDR: if (w_accept) w_next_state = S_MDATA;
            S_MDATA: if (w_accept) begin
                if (w_head.is_reg)       w_next_state = S_RHDR;
                else if (w_head.is_halt) w_next_state = S_HHDR;
                else begin
                    w_next_state = S_IDLE;
                    w_pop        = 1'b1;
                end
            end
            S_RHDR:  if (w_accept) w_next_state = S_RDATA;
            S_RDATA: if (w_accept) begin
                if (w_head.is_halt) w_next_state = S_HHDR;
                else begin
                    w_next_state = S_IDLE;
                    w_pop        = 1'b1;
                end
            end
            S_HHDR:  if (w_accept) w_next_state = S_HCNT;
            S_HCNT:  if (w_accept) begin
                w_next_state = S_DONE;
                w_pop        = 1'b1;
            end
            S_DONE:  w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Serializer FSM with registered valid and done flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tr_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_tr_valid <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
            r_done     <= (w_next_state == S_DONE);
        end
    end

    // Output word selected by the current state from the head entry.
    always_comb begin
        w_tr_data = '0;
        case (r_state)
            S_MHDR:  w_tr_data = w_head.is_store ? 16'h6000 : 16'h4000;
            S_MADDR: w_tr_data = w_head.addr;
            S_MDATA: w_tr_data = w_head.mdata;
            S_RHDR:  w_tr_data = {3'b001, 10'b0, w_head.wreg};
            S_RDATA: w_tr_data = w_head.wdata;
            S_HHDR:  w_tr_data = {3'b111, 5'b0, w_drop8};
            S_HCNT:  w_tr_data = r_inst_count;
            default: w_tr_data = '0;
        endcase
    end

    assign tr_valid   = r_tr_valid;
    assign tr_data    = w_tr_data;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign inst_count = r_inst_count;
    assign done       = r_done;

endmodule

// File: tb/tb_commit_trace_packer.sv
// Directed self-checking bench for commit_trace_packer.
module tb_commit_trace_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite;
    logic [2:0]  WriteRegister;
    logic [15:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] MemAddress;
    logic [15:0] MemDataIn;
    logic [15:0] MemDataOut;
    logic        Halt;
    logic        tr_valid;
    logic [15:0] tr_data;
    logic        tr_ready;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [15:0] inst_count;
    logic        done;

    int total = 0;
    int bad   = 0;
    logic [15:0] got[$];

    commit_trace_packer #(.DEPTH(8), .DROP_W(8)) dut (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut), .Halt(Halt),
        .tr_valid(tr_valid), .tr_data(tr_data), .tr_ready(tr_ready),
        .overflow(overflow), .drop_count(drop_count), .inst_count(inst_count),
        .done(done)
    );

    always #5 clk = ~clk;

    // Words are recorded mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (!rst && tr_valid && tr_ready) got.push_back(tr_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RegWrite = 0; WriteRegister = 0; WriteData = 0;
        MemRead = 0; MemWrite = 0; MemAddress = 0;
        MemDataIn = 0; MemDataOut = 0; Halt = 0;
    endtask

    task automatic drive_event(input logic rw, input logic [2:0] wr, input logic [15:0] wd,
                               input logic mr, input logic mw, input logic [15:0] ad,
                               input logic [15:0] din, input logic [15:0] dout,
                               input logic h);
        RegWrite = rw; WriteRegister = wr; WriteData = wd;
        MemRead = mr; MemWrite = mw; MemAddress = ad;
        MemDataIn = din; MemDataOut = dout; Halt = h;
        tick();
        clear_inputs();
    endtask

    task automatic wait_words(input string tag, input int n);
        int budget = 300;
        while (got.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_count"}, got.size(), n);
    endtask

    task automatic check_stream(input string tag, input int n,
                                input logic [15:0] w0, input logic [15:0] w1 = 0,
                                input logic [15:0] w2 = 0, input logic [15:0] w3 = 0,
                                input logic [15:0] w4 = 0, input logic [15:0] w5 = 0,
                                input logic [15:0] w6 = 0, input logic [15:0] w7 = 0);
        logic [15:0] e [8];
        e = '{w0, w1, w2, w3, w4, w5, w6, w7};
        wait_words(tag, n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_w%0d", tag, i), (i < got.size()) ? got[i] : 16'hxxxx, e[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", tr_valid, 1'b0);
        chk("rst_inst", inst_count, 16'h0);
        chk("rst_drop", drop_count, 8'h0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        got.delete();
        tick();
    endtask

    initial begin
        clear_inputs();
        tr_ready = 1'b1;
        rst = 1'b1;
        tick();
        do_reset();

        // Single register write, latency, then store and halt.
        drive_event(1, 3'd3, 16'h1234, 0, 0, 0, 0, 0, 0);
        chk("lat_idle", tr_valid, 1'b0);
        tick();
        chk("lat_valid", tr_valid, 1'b1);
        chk("lat_data", tr_data, 16'h2003);
        drive_event(0, 0, 0, 0, 1, 16'h0010, 16'h00AA, 16'h5A5A, 0);
        drive_event(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_stream("regstore", 7, 16'h2003, 16'h1234, 16'h6000, 16'h0010,
                     16'h00AA, 16'hE000, 16'h0003);
        repeat (3) tick();
        chk("halt_done", done, 1'b1);
        chk("halt_inst", inst_count, 16'h0003);
        drive_event(1, 3'd1, 16'h9999, 0, 0, 0, 0, 0, 1);
        repeat (4) tick();
        chk("post_halt_inst", inst_count, 16'h0003);
        chk("post_halt_words", got.size(), 7);
        chk("post_halt_valid", tr_valid, 1'b0);
        chk("post_halt_done", done, 1'b1);

        // Load with register write, then a read+write cycle treated as a store.
        do_reset();
        drive_event(1, 3'd5, 16'hBEEF, 1, 0, 16'h0040, 16'h1111, 16'hBEEF, 0);
        drive_event(0, 0, 0, 1, 1, 16'h0020, 16'h5555, 16'h6666, 0);
        check_stream("load", 8, 16'h4000, 16'h0040, 16'hBEEF, 16'h2005, 16'hBEEF,
                     16'h6000, 16'h0020, 16'h5555);
        chk("load_inst", inst_count, 16'h0002);
        chk("load_done", done, 1'b0);

        // Backpressure held for 10 cycles in the address word.
        got.delete();
        drive_event(0, 0, 0, 0, 1, 16'h0030, 16'h7777, 16'h0000, 0);
        wait_words("bp_hdr", 1);
        tr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_data_%0d", i), tr_data, 16'h0030);
            chk($sformatf("bp_valid_%0d", i), tr_valid, 1'b1);
            tick();
        end
        tr_ready = 1'b1;
        check_stream("bp", 3, 16'h6000, 16'h0030, 16'h7777);
        repeat (4) tick();
        chk("bp_nodup", got.size(), 3);

        // Overflow: 9 register writes with the consumer stalled, then halt.
        do_reset();
        tr_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            drive_event(1, i[2:0], 16'h0100 + 16'(i), 0, 0, 0, 0, 0, 0);
        drive_event(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drop", drop_count, 8'd2);
        chk("ovf_inst", inst_count, 16'h000A);
        chk("ovf_hold", tr_data, 16'h2000);
        tr_ready = 1'b1;
        wait_words("ovf", 16);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("ovf_hdr%0d", i), (2*i < got.size()) ? got[2*i] : 16'hxxxx,
                16'h2000 + 16'(i));
            chk($sformatf("ovf_dat%0d", i), (2*i+1 < got.size()) ? got[2*i+1] : 16'hxxxx,
                16'h0100 + 16'(i));
        end
        chk("ovf_hhdr", (got.size() > 14) ? got[14] : 16'hxxxx, 16'hE002);
        chk("ovf_hcnt", (got.size() > 15) ? got[15] : 16'hxxxx, 16'h000A);
        repeat (3) tick();
        chk("ovf_done", done, 1'b1);

        // Reset asserted mid-record in the REG data word.
        do_reset();
        drive_event(1, 3'd2, 16'hABCD, 0, 0, 0, 0, 0, 0);
        wait_words("mid_hdr", 1);
        chk("mid_valid", tr_valid, 1'b1);
        chk("mid_data", tr_data, 16'hABCD);
        chk("mid_inst", inst_count, 16'h0001);
        tr_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", tr_valid, 1'b0);
        chk("mid_rst_inst", inst_count, 16'h0000);
        chk("mid_rst_drop", drop_count, 8'h0);
        chk("mid_rst_ovf", overflow, 1'b0);
        tick();
        rst = 1'b0;
        got.delete();
        tr_ready = 1'b1;
        tick();
        drive_event(1, 3'd6, 16'h0F0F, 0, 0, 0, 0, 0, 0);
        check_stream("after_rst", 2, 16'h2006, 16'h0F0F);
        repeat (3) tick();
        chk("after_rst_words", got.size(), 2);
        chk("after_rst_inst", inst_count, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case something in the sequence never returns.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
